// File: rtl/segre_pkg.sv
// Shared types and geometry for the segre memory stage and its data cache.
package segre_pkg;

  localparam int WORD_SIZE         = 32;
  localparam int ADDR_SIZE         = 32;
  localparam int REG_SIZE          = 5;
  localparam int DCACHE_LANE_SIZE  = 128;
  localparam int DCACHE_LINES      = 4;
  localparam int DCACHE_INDEX_SIZE = 2;
  localparam int DCACHE_BYTE_SIZE  = 4;
  localparam int DCACHE_LANE_BYTES = DCACHE_LANE_SIZE / 8;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } memop_data_type_e;

  typedef enum logic {
    MEM_IDLE,
    MEM_WRITEBACK
  } mem_fsm_state_e;

  // Byte enables within a lane; the offset is aligned down to the access size.
  function automatic logic [DCACHE_LANE_BYTES-1:0] memop_byte_en(
    input memop_data_type_e             t,
    input logic [DCACHE_BYTE_SIZE-1:0]  off
  );
    logic [DCACHE_LANE_BYTES-1:0] mask;
    logic [DCACHE_BYTE_SIZE-1:0]  base;
    case (t)
      BYTE: begin
        mask = DCACHE_LANE_BYTES'(1);
        base = off;
      end
      HALF: begin
        mask = DCACHE_LANE_BYTES'(3);
        base = {off[DCACHE_BYTE_SIZE-1:1], 1'b0};
      end
      default: begin
        mask = DCACHE_LANE_BYTES'(15);
        base = {off[DCACHE_BYTE_SIZE-1:2], 2'b00};
      end
    endcase
    return mask << base;
  endfunction

endpackage

// File: rtl/segre_dcache_data.sv
// Data cache storage: line array, per-line dirty bits, line fill and
// byte-granular store-buffer flush writes.
module segre_dcache_data
  import segre_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rsn_i,
  input  logic                         fill_en,
  input  logic [DCACHE_INDEX_SIZE-1:0] fill_index,
  input  logic [DCACHE_LANE_SIZE-1:0]  fill_data,
  input  logic                         wr_en,
  input  logic [DCACHE_INDEX_SIZE-1:0] wr_index,
  input  logic [DCACHE_BYTE_SIZE-1:0]  wr_offset,
  input  memop_data_type_e             wr_type,
  input  logic [WORD_SIZE-1:0]         wr_data,
  input  logic [DCACHE_INDEX_SIZE-1:0] rd_index,
  output logic [DCACHE_LANE_SIZE-1:0]  rd_line,
  input  logic [DCACHE_INDEX_SIZE-1:0] victim_index,
  output logic [DCACHE_LANE_SIZE-1:0]  victim_line,
  output logic [DCACHE_LINES-1:0]      dirty
);

  logic [DCACHE_LANE_SIZE-1:0]  lines [DCACHE_LINES];
  logic [DCACHE_LINES-1:0]      dirty_q;
  logic [DCACHE_LANE_BYTES-1:0] be;
  logic [DCACHE_LANE_SIZE-1:0]  wr_lane;
  logic [1:0]                   sel;

  // Replicate the store word across the lane so each enabled byte picks its
  // source byte by its position inside the aligned access.
  always_comb begin
    be      = memop_byte_en(wr_type, wr_offset);
    wr_lane = '0;
    sel     = '0;
    for (int unsigned b = 0; b < DCACHE_LANE_BYTES; b++) begin
      sel = 2'(b) & {wr_type == WORD, wr_type != BYTE};
      wr_lane[b*8 +: 8] = wr_data[int'(sel)*8 +: 8];
    end
  end

  // Store bytes are assigned after the fill so they win on a same-line clash.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < DCACHE_LINES; i++) begin
      if (fill_en && fill_index == DCACHE_INDEX_SIZE'(i)) begin
        lines[i] <= fill_data;
      end
      if (wr_en && wr_index == DCACHE_INDEX_SIZE'(i)) begin
        for (int unsigned b = 0; b < DCACHE_LANE_BYTES; b++) begin
          if (be[b]) begin
            lines[i][b*8 +: 8] <= wr_lane[b*8 +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      dirty_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DCACHE_LINES; i++) begin
        if (wr_en && wr_index == DCACHE_INDEX_SIZE'(i)) begin
          dirty_q[i] <= 1'b1;
        end else if (fill_en && fill_index == DCACHE_INDEX_SIZE'(i)) begin
          dirty_q[i] <= 1'b0;
        end
      end
    end
  end

  assign rd_line     = lines[rd_index];
  assign victim_line = lines[victim_index];
  assign dirty       = dirty_q;

endmodule

// File: rtl/segre_mem_stage.sv
// Memory pipeline stage: load/store-buffer path into the data cache, line fills
// and dirty-victim writeback. Define SEGRE_MEM_FILL_FWD_EN to forward fill data
// to a same-cycle load of the same line instead of stalling one cycle.
module segre_mem_stage
  import segre_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rsn_i,
  input  logic [WORD_SIZE-1:0]         addr_i,
  input  logic                         rf_we_i,
  input  logic [REG_SIZE-1:0]          rf_waddr_i,
  input  logic [DCACHE_INDEX_SIZE-1:0] addr_index_i,
  input  logic                         memop_rd_i,
  input  logic                         memop_wr_i,
  input  logic                         memop_sign_ext_i,
  input  memop_data_type_e             memop_type_i,
  input  memop_data_type_e             memop_type_flush_i,
  input  logic                         sb_hit_i,
  input  logic                         sb_flush_i,
  input  logic [WORD_SIZE-1:0]         sb_data_load_i,
  input  logic [WORD_SIZE-1:0]         sb_data_flush_i,
  input  logic [ADDR_SIZE-1:0]         sb_addr_i,
  input  logic                         mmu_data_rdy_i,
  input  logic [DCACHE_LANE_SIZE-1:0]  mmu_data_i,
  input  logic [DCACHE_INDEX_SIZE-1:0] mmu_lru_index_i,
  input  logic [ADDR_SIZE-1:0]         mmu_victim_addr_i,
  output logic                         mmu_wb_req_o,
  output logic [ADDR_SIZE-1:0]         mmu_wb_addr_o,
  output logic [DCACHE_LANE_SIZE-1:0]  mmu_wb_data_o,
  input  logic                         mmu_wb_ack_i,
  output logic                         rf_we_o,
  output logic [REG_SIZE-1:0]          rf_waddr_o,
  output logic [WORD_SIZE-1:0]         rf_wdata_o,
  output logic                         mem_hazard_o
);

  mem_fsm_state_e              state;
  logic [DCACHE_LINES-1:0]     dirty;
  logic [DCACHE_LANE_SIZE-1:0] rd_line;
  logic [DCACHE_LANE_SIZE-1:0] victim_line;
  logic [DCACHE_LANE_SIZE-1:0] line_src;
  logic                        fill_en;
  logic                        flush_en;
  logic                        conflict;
  logic                        hazard;
  logic [WORD_SIZE-1:0]        word_v;
  logic [7:0]                  byte_v;
  logic [15:0]                 half_v;
  logic [WORD_SIZE-1:0]        load_v;
  logic [WORD_SIZE-1:0]        wdata_next;
  logic                        unused_sb_addr;

  assign unused_sb_addr = ^sb_addr_i[ADDR_SIZE-1:DCACHE_BYTE_SIZE];

  assign fill_en  = mmu_data_rdy_i & (state == MEM_IDLE);
  assign conflict = fill_en & memop_rd_i & ~sb_hit_i & (mmu_lru_index_i == addr_index_i);

`ifdef SEGRE_MEM_FILL_FWD_EN
  assign hazard   = rsn_i & (state == MEM_WRITEBACK);
  assign line_src = conflict ? mmu_data_i : rd_line;
`else
  assign hazard   = rsn_i & ((state == MEM_WRITEBACK) | conflict);
  assign line_src = rd_line;
`endif

  assign mem_hazard_o = hazard;
  // A stalled op is replayed by upstream, so its flush is applied only once accepted.
  assign flush_en     = sb_flush_i & memop_wr_i & ~hazard;

  segre_dcache_data u_data (
    .clk_i        (clk_i),
    .rsn_i        (rsn_i),
    .fill_en      (fill_en),
    .fill_index   (mmu_lru_index_i),
    .fill_data    (mmu_data_i),
    .wr_en        (flush_en),
    .wr_index     (addr_index_i),
    .wr_offset    (sb_addr_i[DCACHE_BYTE_SIZE-1:0]),
    .wr_type      (memop_type_flush_i),
    .wr_data      (sb_data_flush_i),
    .rd_index     (addr_index_i),
    .rd_line      (rd_line),
    .victim_index (mmu_lru_index_i),
    .victim_line  (victim_line),
    .dirty        (dirty)
  );

  always_comb begin
    word_v = sb_hit_i ? sb_data_load_i
                      : line_src[int'(addr_i[DCACHE_BYTE_SIZE-1:2])*WORD_SIZE +: WORD_SIZE];
    byte_v = word_v[int'(addr_i[1:0])*8 +: 8];
    half_v = word_v[int'(addr_i[1])*16 +: 16];
    case (memop_type_i)
      BYTE:    load_v = {{(WORD_SIZE-8){memop_sign_ext_i & byte_v[7]}}, byte_v};
      HALF:    load_v = {{(WORD_SIZE-16){memop_sign_ext_i & half_v[15]}}, half_v};
      default: load_v = word_v;
    endcase
    wdata_next = memop_rd_i ? load_v : addr_i;
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state         <= MEM_IDLE;
      rf_we_o       <= 1'b0;
      rf_waddr_o    <= '0;
      rf_wdata_o    <= '0;
      mmu_wb_req_o  <= 1'b0;
      mmu_wb_addr_o <= '0;
      mmu_wb_data_o <= '0;
    end else begin
      rf_we_o <= rf_we_i & ~hazard;
      if (!hazard) begin
        rf_waddr_o <= rf_waddr_i;
        rf_wdata_o <= wdata_next;
      end
      case (state)
        MEM_IDLE: begin
          if (mmu_data_rdy_i && dirty[mmu_lru_index_i]) begin
            mmu_wb_addr_o <= mmu_victim_addr_i;
            mmu_wb_data_o <= victim_line;
            mmu_wb_req_o  <= 1'b1;
            state         <= MEM_WRITEBACK;
          end
        end
        MEM_WRITEBACK: begin
          if (mmu_wb_ack_i) begin
            mmu_wb_req_o <= 1'b0;
            state        <= MEM_IDLE;
          end
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_segre_mem_stage.sv
// Directed bench for segre_mem_stage: loads, flushes, fills, writeback, reset.
module tb_segre_mem_stage;
  import segre_pkg::*;

  logic                         clk_i;
  logic                         rsn_i;
  logic [WORD_SIZE-1:0]         addr_i;
  logic                         rf_we_i;
  logic [REG_SIZE-1:0]          rf_waddr_i;
  logic [DCACHE_INDEX_SIZE-1:0] addr_index_i;
  logic                         memop_rd_i;
  logic                         memop_wr_i;
  logic                         memop_sign_ext_i;
  memop_data_type_e             memop_type_i;
  memop_data_type_e             memop_type_flush_i;
  logic                         sb_hit_i;
  logic                         sb_flush_i;
  logic [WORD_SIZE-1:0]         sb_data_load_i;
  logic [WORD_SIZE-1:0]         sb_data_flush_i;
  logic [ADDR_SIZE-1:0]         sb_addr_i;
  logic                         mmu_data_rdy_i;
  logic [DCACHE_LANE_SIZE-1:0]  mmu_data_i;
  logic [DCACHE_INDEX_SIZE-1:0] mmu_lru_index_i;
  logic [ADDR_SIZE-1:0]         mmu_victim_addr_i;
  logic                         mmu_wb_req_o;
  logic [ADDR_SIZE-1:0]         mmu_wb_addr_o;
  logic [DCACHE_LANE_SIZE-1:0]  mmu_wb_data_o;
  logic                         mmu_wb_ack_i;
  logic                         rf_we_o;
  logic [REG_SIZE-1:0]          rf_waddr_o;
  logic [WORD_SIZE-1:0]         rf_wdata_o;
  logic                         mem_hazard_o;

  int n_tests = 0;
  int n_fail  = 0;

  segre_mem_stage dut (
    .clk_i              (clk_i),
    .rsn_i              (rsn_i),
    .addr_i             (addr_i),
    .rf_we_i            (rf_we_i),
    .rf_waddr_i         (rf_waddr_i),
    .addr_index_i       (addr_index_i),
    .memop_rd_i         (memop_rd_i),
    .memop_wr_i         (memop_wr_i),
    .memop_sign_ext_i   (memop_sign_ext_i),
    .memop_type_i       (memop_type_i),
    .memop_type_flush_i (memop_type_flush_i),
    .sb_hit_i           (sb_hit_i),
    .sb_flush_i         (sb_flush_i),
    .sb_data_load_i     (sb_data_load_i),
    .sb_data_flush_i    (sb_data_flush_i),
    .sb_addr_i          (sb_addr_i),
    .mmu_data_rdy_i     (mmu_data_rdy_i),
    .mmu_data_i         (mmu_data_i),
    .mmu_lru_index_i    (mmu_lru_index_i),
    .mmu_victim_addr_i  (mmu_victim_addr_i),
    .mmu_wb_req_o       (mmu_wb_req_o),
    .mmu_wb_addr_o      (mmu_wb_addr_o),
    .mmu_wb_data_o      (mmu_wb_data_o),
    .mmu_wb_ack_i       (mmu_wb_ack_i),
    .rf_we_o            (rf_we_o),
    .rf_waddr_o         (rf_waddr_o),
    .rf_wdata_o         (rf_wdata_o),
    .mem_hazard_o       (mem_hazard_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // A fill must never be offered while a writeback is outstanding.
  always @(posedge clk_i) begin
    if (rsn_i) begin
      assert (!(mmu_wb_req_o && mmu_data_rdy_i))
        else $error("protocol: fill offered during writeback");
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    addr_i             = '0;
    rf_we_i            = 1'b0;
    rf_waddr_i         = '0;
    addr_index_i       = '0;
    memop_rd_i         = 1'b0;
    memop_wr_i         = 1'b0;
    memop_sign_ext_i   = 1'b0;
    memop_type_i       = WORD;
    memop_type_flush_i = WORD;
    sb_hit_i           = 1'b0;
    sb_flush_i         = 1'b0;
    sb_data_load_i     = '0;
    sb_data_flush_i    = '0;
    sb_addr_i          = '0;
    mmu_data_rdy_i     = 1'b0;
    mmu_data_i         = '0;
    mmu_lru_index_i    = '0;
    mmu_victim_addr_i  = '0;
    mmu_wb_ack_i       = 1'b0;
  endtask

  task automatic set_load(input logic [31:0] a, input logic [1:0] idx,
                          input memop_data_type_e t, input logic sext);
    idle();
    addr_i           = a;
    addr_index_i     = idx;
    memop_rd_i       = 1'b1;
    memop_type_i     = t;
    memop_sign_ext_i = sext;
    rf_we_i          = 1'b1;
    rf_waddr_i       = 5'd5;
  endtask

  task automatic set_fill(input logic [1:0] idx, input logic [127:0] d, input logic [31:0] victim);
    mmu_data_rdy_i    = 1'b1;
    mmu_lru_index_i   = idx;
    mmu_data_i        = d;
    mmu_victim_addr_i = victim;
  endtask

  task automatic set_flush(input logic [1:0] idx, input logic [31:0] a,
                           input memop_data_type_e t, input logic [31:0] d);
    memop_wr_i         = 1'b1;
    sb_flush_i         = 1'b1;
    addr_index_i       = idx;
    sb_addr_i          = a;
    memop_type_flush_i = t;
    sb_data_flush_i    = d;
  endtask

  task automatic load_check(input string tag, input logic [31:0] a, input logic [1:0] idx,
                            input memop_data_type_e t, input logic sext, input logic [31:0] exp);
    set_load(a, idx, t, sext);
    tick();
    check(tag, rf_wdata_o, exp);
  endtask

  initial begin
    int stalls;
    logic accepted;

    idle();
    rsn_i = 1'b0;
    memop_rd_i      = 1'b1;
    mmu_data_rdy_i  = 1'b1;
    #3;
    check("rst_we",       rf_we_o, 0);
    check("rst_waddr",    rf_waddr_o, 0);
    check("rst_wdata",    rf_wdata_o, 0);
    check("rst_wb_req",   mmu_wb_req_o, 0);
    check("rst_wb_addr",  mmu_wb_addr_o, 0);
    check("rst_wb_data",  mmu_wb_data_o, 0);
    check("rst_hazard",   mem_hazard_o, 0);
    idle();
    @(negedge clk_i);
    rsn_i = 1'b1;
    tick();

    // Fill line0, then loads of every size and extension.
    set_fill(2'd0, 128'h33333333_22222222_11111111_F0E1D2C3, 32'h0);
    #1;
    check("fill0_hazard", mem_hazard_o, 0);
    tick();
    idle();
    check("fill0_no_wb", mmu_wb_req_o, 0);
    load_check("lb_signed", 32'h0, 2'd0, BYTE, 1'b1, 32'hFFFFFFC3);
    check("lb_we",    rf_we_o, 1);
    check("lb_waddr", rf_waddr_o, 5);
    load_check("lbu_1",     32'h1, 2'd0, BYTE, 1'b0, 32'h000000D2);
    load_check("lh_2",      32'h2, 2'd0, HALF, 1'b1, 32'hFFFFF0E1);
    load_check("lh_3_align",32'h3, 2'd0, HALF, 1'b0, 32'h0000F0E1);
    load_check("lw_7_align",32'h7, 2'd0, WORD, 1'b0, 32'h11111111);

    idle();
    addr_i = 32'h12345678; rf_we_i = 1'b1; rf_waddr_i = 5'd3;
    tick();
    check("alu_wdata", rf_wdata_o, 32'h12345678);
    check("alu_waddr", rf_waddr_o, 3);

    set_load(32'h3, 2'd0, BYTE, 1'b1);
    sb_hit_i = 1'b1; sb_data_load_i = 32'h8899AABB;
    tick();
    check("sb_hit_lb", rf_wdata_o, 32'hFFFFFF88);

    // Store-buffer flush word into line0 at offset 4.
    idle();
    set_flush(2'd0, 32'h4, WORD, 32'hDEADBEEF);
    tick();
    load_check("lhu_6", 32'h6, 2'd0, HALF, 1'b0, 32'h0000DEAD);
    load_check("lw_4",  32'h4, 2'd0, WORD, 1'b0, 32'hDEADBEEF);

    // Fill over dirty line0: writeback of the old line.
    idle();
    set_fill(2'd0, 128'h44444444_55555555_66666666_77777777, 32'h1000);
    tick();
    idle();
    addr_i = 32'hCAFE; rf_we_i = 1'b1; rf_waddr_i = 5'd9;
    #1;
    check("wb_req",    mmu_wb_req_o, 1);
    check("wb_addr",   mmu_wb_addr_o, 32'h1000);
    check("wb_data",   mmu_wb_data_o, 128'h33333333_22222222_DEADBEEF_F0E1D2C3);
    check("wb_hazard", mem_hazard_o, 1);
    tick();
    check("wb_bubble", rf_we_o, 0);
    tick();
    check("wb_hold_req",  mmu_wb_req_o, 1);
    check("wb_hold_addr", mmu_wb_addr_o, 32'h1000);
    check("wb_hold_data", mmu_wb_data_o, 128'h33333333_22222222_DEADBEEF_F0E1D2C3);
    mmu_wb_ack_i = 1'b1;
    #1;
    check("wb_ack_hazard", mem_hazard_o, 1);
    tick();
    mmu_wb_ack_i = 1'b0;
    #1;
    check("wb_done_req",    mmu_wb_req_o, 0);
    check("wb_done_hazard", mem_hazard_o, 0);
    check("wb_done_bubble", rf_we_o, 0);
    tick();
    check("resume_we",    rf_we_o, 1);
    check("resume_wdata", rf_wdata_o, 32'hCAFE);
    load_check("lw_filled0", 32'h0, 2'd0, WORD, 1'b0, 32'h77777777);

    // Same-cycle fill and byte flush to line1: store byte wins, line dirty.
    idle();
    set_fill(2'd1, 128'h0, 32'h0);
    set_flush(2'd1, 32'h3, BYTE, 32'h123456AA);
    tick();
    load_check("lbu_l1_b3", 32'h3, 2'd1, BYTE, 1'b0, 32'h000000AA);
    load_check("lw_l1_w0",  32'h0, 2'd1, WORD, 1'b0, 32'hAA000000);
    idle();
    set_fill(2'd1, 128'h1, 32'h2000);
    tick();
    idle();
    check("l1_dirty_wb",   mmu_wb_req_o, 1);
    check("l1_wb_addr",    mmu_wb_addr_o, 32'h2000);
    check("l1_wb_data",    mmu_wb_data_o, 128'h000000AA000000);
    mmu_wb_ack_i = 1'b1;
    tick();
    mmu_wb_ack_i = 1'b0;
    check("l1_wb_done", mmu_wb_req_o, 0);

    // Same-cycle load and fill of line2.
    set_load(32'h8, 2'd2, WORD, 1'b0);
    rf_waddr_i = 5'd7;
    set_fill(2'd2, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 32'h0);
    stalls = 0;
    accepted = 1'b0;
    for (int c = 0; c < 4 && !accepted; c++) begin
      #1;
      if (mem_hazard_o) stalls++;
      else accepted = 1'b1;
      tick();
      mmu_data_rdy_i = 1'b0;
    end
    check("ldfill_accept", accepted, 1);
`ifdef SEGRE_MEM_FILL_FWD_EN
    check("ldfill_stalls", stalls, 0);
`else
    check("ldfill_stalls", stalls, 1);
`endif
    check("ldfill_we",    rf_we_o, 1);
    check("ldfill_waddr", rf_waddr_o, 7);
    check("ldfill_data",  rf_wdata_o, 32'h89ABCDEF);
    load_check("lw_l2_w3", 32'hC, 2'd2, WORD, 1'b0, 32'h01234567);

    // Reset in the middle of a writeback.
    idle();
    set_flush(2'd2, 32'h0, WORD, 32'h5555AAAA);
    tick();
    idle();
    set_fill(2'd2, 128'h0, 32'h3000);
    tick();
    idle();
    check("mid_wb_req", mmu_wb_req_o, 1);
    #2;
    rsn_i = 1'b0;
    #1;
    check("rst_mid_wb_req",    mmu_wb_req_o, 0);
    check("rst_mid_wb_addr",   mmu_wb_addr_o, 0);
    check("rst_mid_hazard",    mem_hazard_o, 0);
    @(negedge clk_i);
    rsn_i = 1'b1;
    #1;
    check("post_rst_hazard", mem_hazard_o, 0);
    for (int i = 0; i < 3; i++) begin
      idle();
      set_fill(2'(i), 128'h0, 32'h4000);
      tick();
      idle();
      check($sformatf("post_rst_clean_l%0d", i), mmu_wb_req_o, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
